icache_fetch_responder: RTL and testbench
=========================================

Name: icache_fetch_responder

Overview:
- Direct-mapped instruction cache sitting between the fetch-stage program counter and main memory.
- Answers each fetch address with an instruction in the same cycle on a hit.
- On a miss, asserts a stall to the program counter's stall enable and refills one line from memory over a word-serial request/valid handshake.
- Releases the stall once the line is resident.

Parameters:
- LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS, 8, 32-bit words per line; power of 2, at least 2.
- NOP, 32'h00000013, instruction driven while in reset or stalled.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PC_IN  in  32  fetch byte address from the program counter; bits [1:0] ignored.
- IC_FLUSH  in  1  invalidate all lines.
- IR_OUT  out  32  fetched instruction.
- STALL_OUT  out  1  hold the program counter; drives the PC stall enable.
- MEM_RD_REQ  out  1  word read request to memory.
- MEM_ADDR  out  32  word-aligned read address.
- MEM_RD_DATA  in  32  read data.
- MEM_VALID  in  1  read data valid and request accepted, this cycle.

Behaviour:
- Address split:
  - word offset = PC_IN[2+WB-1:2], WB = log2(WORDS)
  - index = next log2(LINES) bits
  - tag = remaining upper bits
  - Defaults: offset [4:2], index [8:5], tag [31:9].
- Storage:
  - data array LINES×WORDS×32
  - tag array LINES×tag width
  - valid bit per line
- Reset (RST_N low, asynchronous):
  - all valid bits = 0, state = IDLE, word counter = 0, fill address = 0, flush-pending = 0
  - Outputs while RST_N is low: STALL_OUT=0, MEM_RD_REQ=0, MEM_ADDR=0, IR_OUT=NOP
  - Data and tag arrays need no reset.
- State IDLE:
  - hit = valid[index] and tag match. Combinational: IR_OUT = data[index][offset], STALL_OUT=0.
  - On a miss: STALL_OUT=1 and IR_OUT=NOP in the same cycle. Register the line base address (PC_IN with offset and byte bits zeroed) and the index; clear the word counter; go to FILL.
  - IC_FLUSH=1 in IDLE clears all valid bits at the clock edge. The same-cycle lookup still uses the pre-flush valids.
- State FILL:
  - Drive STALL_OUT=1, IR_OUT=NOP, MEM_RD_REQ=1, MEM_ADDR = base + 4×counter.
  - MEM_ADDR is stable until MEM_VALID.
  - On a cycle with MEM_VALID=1, write MEM_RD_DATA to data[index][counter] and increment the counter.
  - When counter = WORDS-1 and MEM_VALID=1:
    - write the tag
    - set valid[index]=1
    - counter wraps to 0
    - go to IDLE
  - MEM_VALID=0 means a wait state: hold everything.
  - Outside FILL, MEM_VALID is ignored.
- Latency:
  - hit: 0 cycles
  - miss with zero-wait memory: STALL_OUT high for WORDS+1 cycles (1 detect cycle + WORDS fill cycles); the following cycle hits.
  - Each memory wait cycle adds 1.
- IC_FLUSH during FILL: latched into flush-pending. The fill completes (line written, valid set), then all valids are cleared on the first IDLE edge. Flush-pending also clears on that edge.
- PC_IN changing during FILL: ignored; the fill finishes for the latched line. The lookup after returning to IDLE uses the current PC_IN.
- Reset mid-FILL: the fill is abandoned, nothing is marked valid, and MEM_RD_REQ drops immediately (asynchronous).
- Conflict miss (same index, different tag): the old line is overwritten. The valid bit is kept at 1 through the fill; the in-progress line cannot be hit because the state is FILL.

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, FILL}
  - NOP constant
  - address-field width functions derived from LINES/WORDS
- Sub-module icache_storage: data, tag and valid arrays; combinational read port, one word-write port, line-valid set, and global valid clear.
- The FSM, counter and handshake stay in the top level.

Test Plan:
- Reset, then PC_IN=0x00000000 with zero-wait memory → STALL_OUT=1 for 9 cycles. MEM_ADDR steps 0x00, 0x04, … 0x1C. Next cycle IR_OUT = word at 0x00 and STALL_OUT=0.
- After that fill, PC_IN=0x00000014 → immediate hit, IR_OUT = memory word 5, no MEM_RD_REQ.
- Memory inserting 2 wait cycles per word on a miss at 0x00000100 → STALL_OUT high 1+8×3=25 cycles; MEM_ADDR held during waits.
- Fill 0x00000000, then PC_IN=0x00000200 (same index 0, new tag) → miss and refill. Then PC_IN=0x00000000 → misses again.
- IC_FLUSH pulsed in the 4th cycle of a fill → fill completes. Two cycles later the same address misses again.
- RST_N low in the 3rd FILL cycle → MEM_RD_REQ=0 and STALL_OUT=0 immediately. After release, the same PC misses and the fill restarts at word 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag covers everything above the index field of a 32-bit byte address.
  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
    return 32 - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_storage.sv
// Data, tag and valid arrays: combinational read, single word write, line-valid set, global clear.
module icache_storage
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [idx_w(LINES)-1:0]         rd_index,
  input  logic [off_w(WORDS)-1:0]         rd_offset,
  output logic [31:0]                     rd_data_c,
  output logic [tag_w(LINES, WORDS)-1:0]  rd_tag_c,
  output logic                            rd_valid_c,
  input  logic                            wr_en,
  input  logic [idx_w(LINES)-1:0]         wr_index,
  input  logic [off_w(WORDS)-1:0]         wr_offset,
  input  logic [31:0]                     wr_data,
  input  logic                            line_set,
  input  logic [tag_w(LINES, WORDS)-1:0]  line_tag,
  input  logic                            clear_all
);

  localparam int unsigned TAG_W = tag_w(LINES, WORDS);

  logic [31:0]      data_q [LINES][WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  assign rd_data_c  = data_q[rd_index][rd_offset];
  assign rd_tag_c   = tag_q[rd_index];
  assign rd_valid_c = valid_q[rd_index];

  // Payload arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index][wr_offset] <= wr_data;
    end
    if (line_set) begin
      tag_q[wr_index] <= line_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (line_set) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped I-cache front end: same-cycle hits, stall plus word-serial line refill on a miss.
module icache_fetch_responder
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 8,
  parameter logic [31:0] NOP   = NOP_INSN
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC_IN,
  input  logic        IC_FLUSH,
  output logic [31:0] IR_OUT,
  output logic        STALL_OUT,
  output logic        MEM_RD_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_RD_DATA,
  input  logic        MEM_VALID
);

  localparam int unsigned OFF_W    = off_w(WORDS);
  localparam int unsigned IDX_W    = idx_w(LINES);
  localparam int unsigned TAG_W    = tag_w(LINES, WORDS);
  localparam int unsigned LINE_LSB = OFF_W + 2;

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [31:0]      base_q, base_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             flush_pend_q, flush_pend_d;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_lsb;

  logic [31:0]      rd_data_c;
  logic [TAG_W-1:0] rd_tag_c;
  logic             rd_valid_c;
  logic             hit_c;

  logic             wr_en_c;
  logic             line_set_c;
  logic             clear_all_c;
  logic             stall_c;
  logic             req_c;
  logic [31:0]      ir_c;
  logic [31:0]      addr_c;

  assign pc_off        = PC_IN[2 +: OFF_W];
  assign pc_idx        = PC_IN[LINE_LSB +: IDX_W];
  assign pc_tag        = PC_IN[31 -: TAG_W];
  assign unused_pc_lsb = ^PC_IN[1:0];

  icache_storage #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_storage (
    .clk        (CLK),
    .rst_n      (RST_N),
    .rd_index   (pc_idx),
    .rd_offset  (pc_off),
    .rd_data_c  (rd_data_c),
    .rd_tag_c   (rd_tag_c),
    .rd_valid_c (rd_valid_c),
    .wr_en      (wr_en_c),
    .wr_index   (idx_q),
    .wr_offset  (cnt_q),
    .wr_data    (MEM_RD_DATA),
    .line_set   (line_set_c),
    .line_tag   (base_q[31 -: TAG_W]),
    .clear_all  (clear_all_c)
  );

  assign hit_c = rd_valid_c && (rd_tag_c == pc_tag);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    idx_d        = idx_q;
    flush_pend_d = flush_pend_q;
    wr_en_c      = 1'b0;
    line_set_c   = 1'b0;
    clear_all_c  = 1'b0;
    stall_c      = 1'b0;
    req_c        = 1'b0;
    ir_c         = NOP;
    addr_c       = '0;

    case (state_q)
      IDLE: begin
        // A flush deferred from the last fill lands on this first idle edge.
        clear_all_c  = IC_FLUSH | flush_pend_q;
        flush_pend_d = 1'b0;
        if (hit_c) begin
          ir_c = rd_data_c;
        end else begin
          stall_c = 1'b1;
          base_d  = {PC_IN[31:LINE_LSB], {LINE_LSB{1'b0}}};
          idx_d   = pc_idx;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        stall_c      = 1'b1;
        req_c        = 1'b1;
        addr_c       = base_q + (32'(cnt_q) << 2);
        flush_pend_d = flush_pend_q | IC_FLUSH;
        if (MEM_VALID) begin
          wr_en_c = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            line_set_c = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces quiet outputs even though an empty cache would otherwise report a miss.
  assign STALL_OUT  = RST_N & stall_c;
  assign IR_OUT     = RST_N ? ir_c : NOP;
  assign MEM_RD_REQ = RST_N & req_c;
  assign MEM_ADDR   = RST_N ? addr_c : '0;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed plus random fetch sequences against a line-level cache model and a word-serial memory.
module tb_icache_fetch_responder;

  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PC_IN;
  logic        IC_FLUSH;
  logic [31:0] IR_OUT;
  logic        STALL_OUT;
  logic        MEM_RD_REQ;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_RD_DATA;
  logic        MEM_VALID;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [1024];
  bit          model_valid [LINES];
  int unsigned model_tag   [LINES];
  int unsigned wait_cycles = 0;

  icache_fetch_responder #(
    .LINES (LINES),
    .WORDS (WORDS),
    .NOP   (NOP)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .PC_IN       (PC_IN),
    .IC_FLUSH    (IC_FLUSH),
    .IR_OUT      (IR_OUT),
    .STALL_OUT   (STALL_OUT),
    .MEM_RD_REQ  (MEM_RD_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_RD_DATA (MEM_RD_DATA),
    .MEM_VALID   (MEM_VALID)
  );

  always #5 CLK = ~CLK;

  // Memory: answers each request after wait_cycles idle cycles with garbage on the data bus meanwhile.
  initial begin : responder
    int unsigned wcnt;
    wcnt        = 0;
    MEM_VALID   = 1'b0;
    MEM_RD_DATA = '0;
    forever begin
      @(negedge CLK);
      if (MEM_RD_REQ === 1'b1) begin
        if (wcnt < wait_cycles) begin
          MEM_VALID   = 1'b0;
          MEM_RD_DATA = $urandom;
          wcnt++;
        end else begin
          MEM_VALID   = 1'b1;
          MEM_RD_DATA = mem[MEM_ADDR[11:2]];
          wcnt        = 0;
        end
      end else begin
        MEM_VALID = 1'b0;
        wcnt      = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned line_of(input logic [31:0] pc);
    return (pc / (4 * WORDS)) % LINES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * WORDS * LINES);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(LINES); i++) model_valid[i] = 1'b0;
  endtask

  // One fetch: hit check, or full miss check with stall length and refill address sequence.
  task automatic fetch(input logic [31:0] pc, input int unsigned w, input int flush_at,
                       input int rst_at, input bit scramble);
    int          n;
    int          k;
    int          exp_n;
    int unsigned idx;
    bit          hit;
    bit          flushed;
    logic [31:0] base;
    idx         = line_of(pc);
    hit         = model_valid[idx] && (model_tag[idx] == tag_of(pc));
    base        = pc & ~32'(4 * WORDS - 1);
    wait_cycles = w;
    @(negedge CLK);
    RST_N    = 1'b1;
    IC_FLUSH = 1'b0;
    PC_IN    = pc;
    #1;
    if (hit) begin
      chk("hit_stall", 32'(STALL_OUT), 32'd0);
      chk("hit_ir", IR_OUT, mem[pc[11:2]]);
      chk("hit_req", 32'(MEM_RD_REQ), 32'd0);
      return;
    end
    exp_n   = 1 + int'(WORDS) * (int'(w) + 1);
    n       = 0;
    k       = 0;
    flushed = 1'b0;
    chk("miss_stall", 32'(STALL_OUT), 32'd1);
    chk("miss_ir_nop", IR_OUT, NOP);
    chk("miss_detect_req", 32'(MEM_RD_REQ), 32'd0);
    while (STALL_OUT === 1'b1 && n < 400) begin
      n++;
      if (MEM_RD_REQ === 1'b1) begin
        chk("fill_addr", MEM_ADDR, base + 32'(4 * k));
        if (MEM_VALID === 1'b1) k++;
      end
      if (n == rst_at) begin
        RST_N = 1'b0;
        #1;
        chk("rst_req", 32'(MEM_RD_REQ), 32'd0);
        chk("rst_stall", 32'(STALL_OUT), 32'd0);
        chk("rst_addr", MEM_ADDR, 32'd0);
        chk("rst_ir", IR_OUT, NOP);
        clear_model();
        return;
      end
      if (n == flush_at) begin
        IC_FLUSH = 1'b1;
        flushed  = 1'b1;
      end
      @(negedge CLK);
      IC_FLUSH = 1'b0;
      PC_IN    = (scramble && (n + 1 < exp_n)) ? (pc ^ 32'h0000_0600) : pc;
      #1;
    end
    chk("stall_cycles", 32'(n), 32'(exp_n));
    chk("after_fill_stall", 32'(STALL_OUT), 32'd0);
    chk("after_fill_ir", IR_OUT, mem[pc[11:2]]);
    model_valid[idx] = 1'b1;
    model_tag[idx]   = tag_of(pc);
    if (flushed) clear_model();
  endtask

  initial begin : main
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    clear_model();
    RST_N    = 1'b0;
    IC_FLUSH = 1'b0;
    PC_IN    = '0;
    #12;
    chk("reset_stall", 32'(STALL_OUT), 32'd0);
    chk("reset_req", 32'(MEM_RD_REQ), 32'd0);
    chk("reset_addr", MEM_ADDR, 32'd0);
    chk("reset_ir", IR_OUT, NOP);

    fetch(32'h0000_0000, 0, 0, 0, 1'b0);
    fetch(32'h0000_0014, 0, 0, 0, 1'b0);
    fetch(32'h0000_0100, 2, 0, 0, 1'b0);
    fetch(32'h0000_0200, 0, 0, 0, 1'b0);
    fetch(32'h0000_0000, 0, 0, 0, 1'b0);

    // Flush in the 4th fill cycle: fill completes, then the line is gone.
    fetch(32'h0000_0040, 0, 5, 0, 1'b0);
    fetch(32'h0000_0040, 0, 0, 0, 1'b0);

    // Flush while idle: same-cycle hit, then everything invalid.
    a = 32'h0000_0044;
    @(negedge CLK);
    PC_IN    = a;
    IC_FLUSH = 1'b1;
    #1;
    chk("idle_flush_ir", IR_OUT, mem[a[11:2]]);
    chk("idle_flush_stall", 32'(STALL_OUT), 32'd0);
    clear_model();
    fetch(a, 0, 0, 0, 1'b0);

    // Reset in the 3rd fill cycle, then the same line refills from word 0.
    fetch(32'h0000_0080, 0, 0, 4, 1'b0);
    fetch(32'h0000_0080, 0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 511)) << 2;
      fetch(a, $urandom_range(0, 2), 0, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
